// File: rtl/keypad_scan.sv
// keypad_scan -- 4x4 matrix keypad scanner with whole-frame debounce.
//
// Drives one column low at a time (rotating active-low one-hot, one step
// every SCAN_CNT cycles), samples the pulled-up rows through a 2-flop
// synchronizer, assembles a 16-bit key image per frame (4 steps), and
// commits an image once it has been seen DEB_FRAMES frames in a row.
// A fresh single-key press emits a one-cycle key_valid with its code.
//
// Parameters:
//   SCAN_CNT   clock cycles per column step (>= 4)
//   DEB_FRAMES identical consecutive frames needed to commit (1..15)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row[3:0]   keypad rows, asynchronous, 0 = pressed
//   col[3:0]   column drive, active-low one-hot
//   key_code   code of the last valid press (col_idx*4 + row_idx)
//   key_valid  one-cycle pulse on a new single-key commit
//   key_down   level: debounced image has at least one key
//   multi      level: debounced image has two or more keys
module keypad_scan #(
  parameter int SCAN_CNT   = 125000,
  parameter int DEB_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       multi
);

  localparam int CNT_W = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             frame_end;
  logic [3:0]       row_m;
  logic [3:0]       row_s;
  logic [1:0]       col_idx;
  logic [15:0]      frame_img;
  logic [15:0]      img_next;
  logic [15:0]      cand;
  logic [15:0]      debounced;
  logic [3:0]       stable_cnt;
  logic [3:0]       cnt_next;
  logic             commit;
  logic             img_one;
  logic             img_multi;
  logic [3:0]       img_code;

  assign tick      = (tick_cnt == CNT_W'(SCAN_CNT - 1));
  // The last column's tick closes the frame; its own samples are included
  // through img_next rather than the not-yet-updated frame_img.
  assign frame_end = tick && (col == 4'b0111);

  // NOTE: every signal written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    col_idx = 2'd0;
    case (col)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Frame image including the bits sampled this cycle (1 = pressed).
  always_comb begin
    img_next = frame_img;
    img_next[{col_idx, 2'b00} +: 4] = ~row_s;
  end

  // Debounce bookkeeping as it would look after this frame end.
  always_comb begin
    cnt_next = 4'd1;
    if (img_next == cand) begin
      cnt_next = (stable_cnt == 4'd15) ? 4'd15 : stable_cnt + 4'd1;
    end
    commit = frame_end && (cnt_next == 4'(DEB_FRAMES));
  end

  // Classification of the image about to be committed.
  always_comb begin
    img_multi = (img_next & (img_next - 16'd1)) != 16'd0;
    img_one   = (img_next != 16'd0) && !img_multi;
    img_code  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (img_next[i]) img_code = 4'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      col        <= 4'b1110;
      row_m      <= 4'b1111;
      row_s      <= 4'b1111;
      frame_img  <= '0;
      cand       <= '0;
      debounced  <= '0;
      stable_cnt <= '0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      key_down   <= 1'b0;
      multi      <= 1'b0;
    end else begin
      row_m     <= row;
      row_s     <= row_m;
      key_valid <= 1'b0;

      if (tick) begin
        tick_cnt  <= '0;
        col       <= {col[2:0], col[3]};
        frame_img <= img_next;
      end else begin
        tick_cnt <= tick_cnt + CNT_W'(1);
      end

      if (frame_end) begin
        cand       <= img_next;
        stable_cnt <= cnt_next;
      end

      // Outputs are loaded on the commit edge itself, so they become
      // visible in the cycle right after the frame end.
      if (commit) begin
        debounced <= img_next;
        key_down  <= |img_next;
        multi     <= img_multi;
        // Only a clean transition from "nothing held" to one key counts.
        if (img_one && (debounced == 16'd0)) begin
          key_valid <= 1'b1;
          key_code  <= img_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with SCAN_CNT=4, DEB_FRAMES=3
// (one frame = 16 cycles). A keypad model turns a 16-bit set of held keys
// into row levels for whichever column is driven low.
module tb_keypad_scan;

  localparam int SCAN = 4;
  localparam int DEB  = 3;
  localparam int FRAME = 4 * SCAN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       multi;

  logic [15:0] keys = 16'h0000;

  int n_checks = 0;
  int n_pass   = 0;

  keypad_scan #(.SCAN_CNT(SCAN), .DEB_FRAMES(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .multi     (multi)
  );

  always #5 clk = ~clk;

  // Keypad: a held key at (c, r) pulls row r low while column c is driven.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      if (col[c] == 1'b0) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[c*4 + r]) row[r] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;  // now in cycle 0 after release
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [3:0] code,
                            input logic d, input logic m);
    check({tag, " key_valid"}, 32'(key_valid), 32'(v));
    check({tag, " key_code"},  32'(key_code),  32'(code));
    check({tag, " key_down"},  32'(key_down),  32'(d));
    check({tag, " multi"},     32'(multi),     32'(m));
  endtask

  // Hold a key set for one whole frame; returns in cycle 0 of the next frame.
  task automatic run_frame(input logic [15:0] k, input string tag);
    keys = k;
    repeat (FRAME / 2) cyc();
    check({tag, " mid-frame key_valid"}, 32'(key_valid), 32'd0);
    repeat (FRAME / 2) cyc();
  endtask

  typedef struct {
    logic [15:0] keys;
    logic        vld;
    logic [3:0]  code;
    logic        down;
    logic        mul;
  } vec_t;

  vec_t tbl[26];

  // Reference: frame history with run-length debounce.
  logic [15:0] m_hist[$];
  logic [15:0] m_deb;
  logic [3:0]  m_code;
  logic        m_vld, m_down, m_multi;

  function automatic int popcnt(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic model_frame(input logic [15:0] img);
    int run = 0;
    m_hist.push_back(img);
    if (m_hist.size() > 16) void'(m_hist.pop_front());
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] != img || run == 15) break;
      run++;
    end
    m_vld = 1'b0;
    if (run == DEB) begin
      if (popcnt(img) == 1 && m_deb == 16'd0) begin
        m_vld = 1'b1;
        for (int i = 0; i < 16; i++) if (img[i]) m_code = 4'(i);
      end
      m_deb   = img;
      m_down  = popcnt(img) >= 1;
      m_multi = popcnt(img) >= 2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_col;
    logic [15:0] rk;
    int a, b;

    tbl[0]  = '{16'h0200, 1'b0, 4'd0,  1'b0, 1'b0};
    tbl[1]  = '{16'h0200, 1'b0, 4'd0,  1'b0, 1'b0};
    tbl[2]  = '{16'h0200, 1'b1, 4'd9,  1'b1, 1'b0};
    tbl[3]  = '{16'h0200, 1'b0, 4'd9,  1'b1, 1'b0};
    tbl[4]  = '{16'h0000, 1'b0, 4'd9,  1'b1, 1'b0};
    tbl[5]  = '{16'h0000, 1'b0, 4'd9,  1'b1, 1'b0};
    tbl[6]  = '{16'h0000, 1'b0, 4'd9,  1'b0, 1'b0};
    tbl[7]  = '{16'h0001, 1'b0, 4'd9,  1'b0, 1'b0};
    tbl[8]  = '{16'h0000, 1'b0, 4'd9,  1'b0, 1'b0};
    tbl[9]  = '{16'h0000, 1'b0, 4'd9,  1'b0, 1'b0};
    tbl[10] = '{16'h0000, 1'b0, 4'd9,  1'b0, 1'b0};
    tbl[11] = '{16'h0021, 1'b0, 4'd9,  1'b0, 1'b0};
    tbl[12] = '{16'h0021, 1'b0, 4'd9,  1'b0, 1'b0};
    tbl[13] = '{16'h0021, 1'b0, 4'd9,  1'b1, 1'b1};
    tbl[14] = '{16'h0020, 1'b0, 4'd9,  1'b1, 1'b1};
    tbl[15] = '{16'h0020, 1'b0, 4'd9,  1'b1, 1'b1};
    tbl[16] = '{16'h0020, 1'b0, 4'd9,  1'b1, 1'b0};
    tbl[17] = '{16'h8000, 1'b0, 4'd9,  1'b1, 1'b0};
    tbl[18] = '{16'h8000, 1'b0, 4'd9,  1'b1, 1'b0};
    tbl[19] = '{16'h8000, 1'b0, 4'd9,  1'b1, 1'b0};
    tbl[20] = '{16'h0000, 1'b0, 4'd9,  1'b1, 1'b0};
    tbl[21] = '{16'h0000, 1'b0, 4'd9,  1'b1, 1'b0};
    tbl[22] = '{16'h0000, 1'b0, 4'd9,  1'b0, 1'b0};
    tbl[23] = '{16'h8000, 1'b0, 4'd9,  1'b0, 1'b0};
    tbl[24] = '{16'h8000, 1'b0, 4'd9,  1'b0, 1'b0};
    tbl[25] = '{16'h8000, 1'b1, 4'd15, 1'b1, 1'b0};

    // Reset values while rst_n is low, then column rotation with no key.
    keys = 16'h0000;
    #12;
    check("reset col", 32'(col), 32'h0e);
    check_outs("reset", 1'b0, 4'd0, 1'b0, 1'b0);
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c > 0) cyc();
      exp_col = 4'b1110;
      for (int s = 0; s < (c / SCAN) % 4; s++) exp_col = {exp_col[2:0], exp_col[3]};
      check($sformatf("rotation col c%0d", c), 32'(col), 32'(exp_col));
      if (c % 4 == 3) check_outs($sformatf("rotation c%0d", c), 1'b0, 4'd0, 1'b0, 1'b0);
    end

    // Directed frame table from a fresh reset.
    do_reset();
    for (int i = 0; i < 26; i++) begin
      run_frame(tbl[i].keys, $sformatf("tbl%0d", i));
      check_outs($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].code, tbl[i].down, tbl[i].mul);
      cyc();  // key_valid must have dropped after one cycle
      check($sformatf("tbl%0d pulse width", i), 32'(key_valid), 32'd0);
      repeat (FRAME - 1) cyc();  // finish the frame with the same keys held
      // the extra frame keeps the same keys, so rewind expectations by
      // re-running the previous entry only when it is stable: handled by
      // the table ordering (each extra frame is a repeat of tbl[i].keys)
      break;
    end

    // Clean restart of the table with no extra frames between entries.
    do_reset();
    for (int i = 0; i < 26; i++) begin
      run_frame(tbl[i].keys, $sformatf("seq%0d", i));
      check_outs($sformatf("seq%0d", i), tbl[i].vld, tbl[i].code, tbl[i].down, tbl[i].mul);
    end

    // Glitch inside a frame: key 0 held for only one column step.
    do_reset();
    keys = 16'h0001;
    repeat (SCAN) cyc();
    keys = 16'h0000;
    repeat (FRAME * 4 - SCAN) cyc();
    check_outs("glitch", 1'b0, 4'd0, 1'b0, 1'b0);

    // Reset mid-press with code 9 held, then a fresh commit at cycle 48.
    do_reset();
    keys = 16'h0200;
    repeat (3 * FRAME + 5) cyc();
    check("pre-reset key_down", 32'(key_down), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-reset col", 32'(col), 32'h0e);
    check_outs("mid-reset", 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 1; c <= 49; c++) begin
      cyc();
      if (c == 47) check("rst-press c47 key_valid", 32'(key_valid), 32'd0);
      if (c == 48) check_outs("rst-press c48", 1'b1, 4'd9, 1'b1, 1'b0);
      if (c == 49) check("rst-press c49 key_valid", 32'(key_valid), 32'd0);
    end

    // Randomized frames against the reference model.
    do_reset();
    keys = 16'h0000;
    m_hist.delete();
    m_deb = '0; m_code = '0; m_vld = 1'b0; m_down = 1'b0; m_multi = 1'b0;
    rk = 16'h0000;
    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: rk = rk;
        5, 6:          rk = 16'h0000;
        7, 8:          rk = 16'(1) << $urandom_range(0, 15);
        default: begin
          a = $urandom_range(0, 15);
          b = (a + $urandom_range(1, 15)) % 16;
          rk = (16'(1) << a) | (16'(1) << b);
        end
      endcase
      run_frame(rk, $sformatf("rnd%0d", f));
      model_frame(rk);
      check_outs($sformatf("rnd%0d", f), m_vld, m_code, m_down, m_multi);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
